// File: rtl/rf_seq_pkg.sv
// rtl/rf_seq_pkg.sv - shared state type and sizing constants for the bit-serial register-file sequencer
package rf_seq_pkg;

  localparam int RF_XLEN = 32;
  localparam int RF_AW   = 5;

  // Cycles from an accepted start to the next accepted start.
  localparam int SEQ_LAT = RF_XLEN + 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WB    = 2'd3
  } rf_seq_state_e;

endpackage

// File: rtl/rf_seq_shifter.sv
// rtl/rf_seq_shifter.sv - operand shift registers (LSB-first out) and MSB-first result collector
module rf_seq_shifter
  import rf_seq_pkg::*;
#(
  parameter int XLEN = RF_XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            res_bit_i,
  output logic            a_bit_o,
  output logic            b_bit_o,
  output logic [XLEN-1:0] res_o
);

  logic [XLEN-1:0] sha_q, sha_d;
  logic [XLEN-1:0] shb_q, shb_d;
  logic [XLEN-1:0] shr_q, shr_d;

  // Result bits enter at the MSB so after XLEN shifts bit 0 lands at shr[0].
  always_comb begin
    sha_d = sha_q;
    shb_d = shb_q;
    shr_d = shr_q;
    if (load_i) begin
      sha_d = a_i;
      shb_d = b_i;
    end else if (shift_i) begin
      sha_d = {1'b0, sha_q[XLEN-1:1]};
      shb_d = {1'b0, shb_q[XLEN-1:1]};
      shr_d = {res_bit_i, shr_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sha_q <= '0;
      shb_q <= '0;
      shr_q <= '0;
    end else begin
      sha_q <= sha_d;
      shb_q <= shb_d;
      shr_q <= shr_d;
    end
  end

  assign a_bit_o = sha_q[0];
  assign b_bit_o = shb_q[0];
  assign res_o   = shr_q;

endmodule

// File: rtl/rf_serial_seq.sv
// rtl/rf_serial_seq.sv - bit-serial operand sequencer between register file and serial ALU; RFSEQ_ABORT_EN adds abort
module rf_serial_seq
  import rf_seq_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int AW   = RF_AW,
  parameter int CW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  input  logic [AW-1:0]   rd_i,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic            rf_we,
  output logic            op_a_bit,
  output logic            op_b_bit,
  output logic            bit_valid,
  output logic            bit_first,
  output logic            bit_last,
  input  logic            res_bit
`ifdef RFSEQ_ABORT_EN
  ,
  input  logic            abort
`endif
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_WB    = ST_WB;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rs1_q, rs2_q, rd_q;
  logic            accept, cnt_last, abort_w;
  logic            sh_a_bit, sh_b_bit;
  logic [XLEN-1:0] shr;

`ifdef RFSEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign accept   = (state_q == S_IDLE) && start;
  assign cnt_last = (cnt_q == CW'(XLEN - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_last) state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An abort past SHIFT is too late: the write-back cycle always completes.
    if (abort_w && ((state_q == S_LOAD) || (state_q == S_SHIFT))) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rs1_q <= rs1_i;
        rs2_q <= rs2_i;
        rd_q  <= rd_i;
      end
    end
  end

  rf_seq_shifter #(.XLEN(XLEN)) u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (state_q == S_LOAD),
    .shift_i   (state_q == S_SHIFT),
    .a_i       (rf_rd1),
    .b_i       (rf_rd2),
    .res_bit_i (res_bit),
    .a_bit_o   (sh_a_bit),
    .b_bit_o   (sh_b_bit),
    .res_o     (shr)
  );

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_WB);
  assign rf_we     = done && (rd_q != '0);
  assign rf_rs1    = rs1_q;
  assign rf_rs2    = rs2_q;
  assign rf_rd     = rd_q;
  assign rf_wd     = shr;
  assign bit_valid = (state_q == S_SHIFT);
  assign bit_first = bit_valid && (cnt_q == '0);
  assign bit_last  = bit_valid && cnt_last;
  assign op_a_bit  = bit_valid && sh_a_bit;
  assign op_b_bit  = bit_valid && sh_b_bit;

endmodule

// File: tb/tb_rf_serial_seq.sv
// tb/tb_rf_serial_seq.sv - scoreboard bench for rf_serial_seq with register-file and serial-adder models
module tb_rf_serial_seq;
  import rf_seq_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn, start;
  logic [AW-1:0]   rs1_i, rs2_i, rd_i;
  logic            busy, done, rf_we;
  logic [AW-1:0]   rf_rs1, rf_rs2, rf_rd;
  logic [XLEN-1:0] rf_rd1, rf_rd2, rf_wd;
  logic            op_a_bit, op_b_bit, bit_valid, bit_first, bit_last, res_bit;
`ifdef RFSEQ_ABORT_EN
  logic            abort;
`endif

  rf_serial_seq #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .busy(busy), .done(done),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_rd(rf_rd), .rf_wd(rf_wd), .rf_we(rf_we),
    .op_a_bit(op_a_bit), .op_b_bit(op_b_bit),
    .bit_valid(bit_valid), .bit_first(bit_first), .bit_last(bit_last),
    .res_bit(res_bit)
`ifdef RFSEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  // Register file environment, reset by the same rstn, with a preload port.
  logic [XLEN-1:0] rf_mem [32];
  logic            pl_en;
  logic [AW-1:0]   pl_addr;
  logic [XLEN-1:0] pl_data;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else begin
      if (rf_we && (rf_rd != '0)) rf_mem[rf_rd] <= rf_wd;
      if (pl_en) rf_mem[pl_addr] <= pl_data;
    end
  end
  assign rf_rd1 = (rf_rs1 == '0) ? '0 : rf_mem[rf_rs1];
  assign rf_rd2 = (rf_rs2 == '0) ? '0 : rf_mem[rf_rs2];

  // Serial adder environment.
  logic carry_q, cin;
  assign cin     = bit_first ? 1'b0 : carry_q;
  assign res_bit = op_a_bit ^ op_b_bit ^ cin;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) carry_q <= 1'b0;
    else if (bit_valid) carry_q <= (op_a_bit & op_b_bit) | (op_a_bit & cin) | (op_b_bit & cin);
  end

  typedef struct {
    int              acc;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } exp_t;

  logic [XLEN-1:0] ref_rf [32];
  exp_t sb[$];
  int   cyc = 0;
  int   free_edge = 0;
  int   last_acc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic wait_free();
    while (cyc + 1 < free_edge) @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [XLEN-1:0] v);
    wait_free();
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(negedge clk);
    pl_en = 1'b0;
    if (a != '0) ref_rf[a] = v;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d);
    exp_t e;
    wait_free();
    start = 1'b1; rs1_i = a; rs2_i = b; rd_i = d;
    e.acc  = cyc + 1;
    e.rd   = d;
    e.data = ref_rf[a] + ref_rf[b];
    if (d != '0) ref_rf[d] = e.data;
    sb.push_back(e);
    free_edge = e.acc + SEQ_LAT;
    last_acc  = e.acc;
    @(negedge clk);
    start = 1'b0;
    rs1_i = AW'($urandom); rs2_i = AW'($urandom); rd_i = AW'($urandom);
  endtask

  task automatic wait_d(input int target);
    while (cyc - last_acc < target) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 4 * SEQ_LAT) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctrl"}, {busy, done, rf_we, bit_valid, bit_first, bit_last, op_a_bit, op_b_bit}, 0);
    chk({tag, "_addr"}, {rf_rs1, rf_rs2, rf_rd}, 0);
    chk({tag, "_wd"}, rf_wd, 0);
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    free_edge = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write-back.
  always @(negedge clk) begin
    int   d;
    exp_t e;
    if (rstn) begin
      d = (sb.size() > 0) ? (cyc - sb[0].acc) : -1;
      if (bit_first) chk("bit_first_cycle", d, 1);
      if (bit_last)  chk("bit_last_cycle", d, XLEN);
      if (rf_we)     chk("we_with_done", done, 1);
      if (done) begin
        if (sb.size() == 0) begin
          chk("wb_expected", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", d, XLEN + 1);
          chk("wb_rd", rf_rd, e.rd);
          chk("wb_data", rf_wd, e.data);
          chk("wb_we", rf_we, e.rd != '0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] saved;
    rstn = 1'b0; start = 1'b0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
`ifdef RFSEQ_ABORT_EN
    abort = 1'b0;
`endif
    model_reset();
    #1;
    check_reset_vals("por");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 5 + 3 into x3
    preload(5'd1, 32'h5);
    preload(5'd2, 32'h3);
    issue(5'd1, 5'd2, 5'd3);
    drain();
    chk("x3_sum", rf_mem[3], 32'h8);

    // Wrap to zero, then a back-to-back read of the just-written register
    preload(5'd4, 32'hFFFF_FFFF);
    preload(5'd5, 32'h1);
    issue(5'd4, 5'd5, 5'd4);
    issue(5'd4, 5'd5, 5'd6);
    drain();
    chk("x4_wrap", rf_mem[4], 32'h0);
    chk("x6_fwd", rf_mem[6], 32'h1);

    // rd = 0 never writes; x0 as a source reads 0
    issue(5'd1, 5'd2, 5'd0);
    issue(5'd0, 5'd1, 5'd7);
    drain();
    chk("x7_from_x0", rf_mem[7], 32'h5);

    // Starts during an active op are ignored
    issue(5'd1, 5'd2, 5'd8);
    wait_d(5);
    start = 1'b1; rs1_i = 5'd4; rs2_i = 5'd5; rd_i = 5'd9;
    @(negedge clk);
    start = 1'b0;
    wait_d(20);
    start = 1'b1; rs1_i = 5'd1; rs2_i = 5'd1; rd_i = 5'd9;
    @(negedge clk);
    start = 1'b0;
    drain();
    chk("x8_sum", rf_mem[8], 32'h8);
    chk("x9_untouched", rf_mem[9], 32'h0);

    // Reset mid-SHIFT
    preload(5'd10, 32'h1234_5678);
    preload(5'd11, 32'h1111_1111);
    issue(5'd10, 5'd11, 5'd12);
    wait_d(16);
    rstn = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("x12_after_reset", rf_mem[12], 32'h0);

`ifdef RFSEQ_ABORT_EN
    preload(5'd13, 32'h7);
    preload(5'd14, 32'h9);
    saved = ref_rf[15];
    issue(5'd13, 5'd14, 5'd15);
    wait_d(9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    void'(sb.pop_back());
    ref_rf[15] = saved;
    free_edge  = cyc + 1;
    repeat (SEQ_LAT + 5) @(negedge clk);
    chk("abort_no_write", rf_mem[15], saved);
    issue(5'd13, 5'd14, 5'd15);
    drain();
    chk("abort_retry", rf_mem[15], 32'h10);
`else
    saved = '0;
`endif

    // Randomized traffic against the reference model
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0)
        preload(AW'($urandom_range(1, 31)), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(AW'($urandom), AW'($urandom), AW'($urandom));
    end
    drain();
    for (int i = 1; i < 32; i++) chk($sformatf("final_x%0d", i), rf_mem[i], ref_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
